// File: rtl/sram_responder.sv
// sram_responder: 2048 x 16 word store answering the adrx/nOE/read/data SRAM
// bus. Drives data only during legal reads, flags illegal bus states, and keeps
// saturating read/write transaction counters for bring-up debug.
// Optional feature macro: SRAM_RESPONDER_CLEAR_EN builds the post-reset zeroing
// sweep (CLEAR state); without it reset goes straight to RUN.
module sram_responder #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      adrx,
    input  logic                   nOE,
    input  logic                   read,
    inout  wire logic [DATA_W-1:0] data,
    output logic                   ready,
    output logic                   err,
    output logic [15:0]            wr_count,
    output logic [15:0]            rd_count
);

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_RD,
        BUS_WR,
        BUS_ILLEGAL
    } bus_e;

    bus_e              bus;
    logic              run;
    logic              clearing;
    logic              ready_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              drive_en;

    logic              ready_q;
    logic              err_q, err_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [15:0]       rd_count_q, rd_count_d;
    logic              prev_rd_q, prev_rd_d;
    logic [ADDR_W-1:0] adrx_q;

    // Decode the bus state from the nOE/read pair
    always_comb begin
        bus = BUS_ILLEGAL;
        case ({nOE, read})
            2'b01:   bus = BUS_RD;
            2'b10:   bus = BUS_WR;
            2'b11:   bus = BUS_IDLE;
            default: bus = BUS_ILLEGAL;
        endcase
    end

`ifdef SRAM_RESPONDER_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // State register and sweep address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: sweep every address once, then run
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    assign run      = (state_q == ST_RUN);
    assign clearing = (state_q == ST_CLEAR);
    assign ready_d  = (state_d == ST_RUN);
`else
    assign run      = 1'b1;
    assign clearing = 1'b0;
    assign ready_d  = 1'b1;
`endif

    // Outputs: array write port, bus drive enable and counter next values
    always_comb begin
        mem_we     = 1'b0;
        mem_waddr  = adrx;
        mem_wdata  = data;
        drive_en   = 1'b0;
        err_d      = err_q;
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        prev_rd_d  = 1'b0;

        if (bus == BUS_ILLEGAL) begin
            err_d = 1'b1;
        end

`ifdef SRAM_RESPONDER_CLEAR_EN
        if (clearing) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end
`endif

        if (run) begin
            if (bus == BUS_WR) begin
                mem_we = 1'b1;
                if (wr_count_q != '1) begin
                    wr_count_d = wr_count_q + 16'd1;
                end
            end
            if (bus == BUS_RD) begin
                drive_en  = 1'b1;
                prev_rd_d = 1'b1;
                if ((!prev_rd_q || (adrx != adrx_q)) && (rd_count_q != '1)) begin
                    rd_count_d = rd_count_q + 16'd1;
                end
            end
        end

        // Reset must release the bus at once and drop any write at a reset edge;
        // the array itself has no reset, so the write enable is gated here.
        if (rst) begin
            mem_we   = 1'b0;
            drive_en = 1'b0;
        end
    end

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Status flags, counters and previous-read tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef SRAM_RESPONDER_CLEAR_EN
            ready_q <= 1'b0;
`else
            ready_q <= 1'b1;
`endif
            err_q      <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            prev_rd_q  <= 1'b0;
            adrx_q     <= '0;
        end else begin
            ready_q    <= ready_d;
            err_q      <= err_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            prev_rd_q  <= prev_rd_d;
            adrx_q     <= adrx;
        end
    end

    assign data     = drive_en ? mem[adrx] : 'z;
    assign ready    = ready_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder.
// Follows SRAM_RESPONDER_CLEAR_EN so both builds are checked against their own
// expected reset behaviour.
module tb_sram_responder;

`ifdef SRAM_RESPONDER_CLEAR_EN
    localparam int unsigned CLR_CYC   = 2048;
    localparam logic        RST_READY = 1'b0;
`else
    localparam int unsigned CLR_CYC   = 0;
    localparam logic        RST_READY = 1'b1;
`endif

    logic        clk;
    logic        rst;
    logic [10:0] adrx;
    logic        nOE;
    logic        read;
    logic [15:0] drv;
    logic        drv_en;
    wire  logic [15:0] data;
    logic        ready;
    logic        err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    int unsigned errors;
    int unsigned checks;

    assign data = drv_en ? drv : 'z;

    sram_responder #(
        .ADDR_W(11),
        .DATA_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .adrx     (adrx),
        .nOE      (nOE),
        .read     (read),
        .data     (data),
        .ready    (ready),
        .err      (err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A 2-state simulator resolves an undriven bus to zero, so accept that as released.
    function automatic bit released(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    // One bus cycle: inputs change on the falling edge, sampled at the next rising edge.
    task automatic cyc(input logic n_oe, input logic rd, input logic [10:0] a,
                       input logic den, input logic [15:0] dv);
        @(negedge clk);
        nOE    = n_oe;
        read   = rd;
        adrx   = a;
        drv_en = den;
        drv    = dv;
    endtask

    task automatic bus_idle();
        cyc(1'b1, 1'b1, 11'd0, 1'b0, 16'h0000);
    endtask

    // Release reset (caller sits at a falling edge) and measure cycles until ready.
    task automatic release_and_wait();
        int unsigned n;
        rst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != CLR_CYC) begin
            errors++;
            $display("FAIL ready_latency: got %0d cycles, expected %0d", n, CLR_CYC);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        nOE = 1'b1; read = 1'b1; drv_en = 1'b0; adrx = '0;
        @(negedge clk);
        @(negedge clk);
        release_and_wait();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        nOE = 1'b1; read = 1'b1; drv_en = 1'b0; adrx = '0;
        #1;
        checks++;
        if (ready !== RST_READY) begin errors++; $display("FAIL rst_ready: got %b expected %b", ready, RST_READY); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++;
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL rst_wr_count: got %h expected 0000", wr_count); end
        checks++;
        if (rd_count !== 16'h0000) begin errors++; $display("FAIL rst_rd_count: got %h expected 0000", rd_count); end
        checks++;
        if (!released(data)) begin errors++; $display("FAIL rst_data_z: got %h expected released", data); end
        @(negedge clk);
        release_and_wait();
`ifdef SRAM_RESPONDER_CLEAR_EN
        cyc(1'b0, 1'b1, 11'd0, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL clr_rd0: got %h expected 0000", data); end
        cyc(1'b0, 1'b1, 11'd1023, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL clr_rd1023: got %h expected 0000", data); end
        cyc(1'b0, 1'b1, 11'd2047, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL clr_rd2047: got %h expected 0000", data); end
        bus_idle();
        #1; checks++;
        if (rd_count !== 16'd3) begin errors++; $display("FAIL clr_rd_count: got %0d expected 3", rd_count); end
`else
        bus_idle();
        #1; checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %b expected 1", ready); end
`endif
    endtask

    task automatic test_driver_pattern();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            cyc(1'b1, 1'b0, 11'(i), 1'b1, 16'(127 - i));
            bus_idle();
        end
        for (int i = 0; i < 128; i++) begin
            cyc(1'b0, 1'b1, 11'(i), 1'b0, 16'h0000);
            #1; checks++;
            if (data !== 16'(127 - i)) begin
                errors++;
                $display("FAIL pattern_rd[%0d]: got %h expected %h", i, data, 16'(127 - i));
            end
        end
        bus_idle();
        #1; checks++;
        if (wr_count !== 16'd128) begin errors++; $display("FAIL pattern_wr_count: got %0d expected 128", wr_count); end
        checks++;
        if (rd_count !== 16'd128) begin errors++; $display("FAIL pattern_rd_count: got %0d expected 128", rd_count); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL pattern_err: got %b expected 0", err); end
    endtask

    task automatic test_held_read();
        do_reset();
        cyc(1'b1, 1'b0, 11'd5, 1'b1, 16'h1234);
        bus_idle();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 11'd5, 1'b0, 16'h0000);
            #1; checks++;
            if (data !== 16'h1234) begin errors++; $display("FAIL held_rd[%0d]: got %h expected 1234", i, data); end
        end
        bus_idle();
        #1; checks++;
        if (!released(data)) begin errors++; $display("FAIL held_idle_z: got %h expected released", data); end
        checks++;
        if (rd_count !== 16'd1) begin errors++; $display("FAIL held_rd_count1: got %0d expected 1", rd_count); end
        cyc(1'b0, 1'b1, 11'd5, 1'b0, 16'h0000);
        bus_idle();
        #1; checks++;
        if (rd_count !== 16'd2) begin errors++; $display("FAIL held_rd_count2: got %0d expected 2", rd_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        cyc(1'b1, 1'b0, 11'd9, 1'b1, 16'hBEEF);
        bus_idle();
        #1; checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ill_err_pre: got %b expected 0", err); end
        cyc(1'b0, 1'b0, 11'd9, 1'b0, 16'h0000);
        #1; checks++;
        if (!released(data)) begin errors++; $display("FAIL ill_data_z: got %h expected released", data); end
        cyc(1'b0, 1'b0, 11'd9, 1'b1, 16'h1111);
        bus_idle();
        #1; checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL ill_err_set: got %b expected 1", err); end
        repeat (5) bus_idle();
        #1; checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL ill_err_sticky: got %b expected 1", err); end
        cyc(1'b0, 1'b1, 11'd9, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'hBEEF) begin errors++; $display("FAIL ill_mem9: got %h expected beef", data); end
        bus_idle();
        #1; checks++;
        if (wr_count !== 16'd1) begin errors++; $display("FAIL ill_wr_count: got %0d expected 1", wr_count); end
    endtask

    task automatic test_saturation();
        do_reset();
        cyc(1'b1, 1'b0, 11'd100, 1'b1, 16'hA5A5);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_wr_fffe: got %h expected fffe", wr_count); end
        repeat (3) @(posedge clk);
        bus_idle();
        #1; checks++;
        if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_wr_ffff: got %h expected ffff", wr_count); end
        checks++;
        if (rd_count !== 16'h0000) begin errors++; $display("FAIL sat_rd_count: got %h expected 0000", rd_count); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        cyc(1'b1, 1'b0, 11'd20, 1'b1, 16'h0F0F);
        bus_idle();
        cyc(1'b0, 1'b1, 11'd20, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'h0F0F) begin errors++; $display("FAIL mid_rd_pre: got %h expected 0f0f", data); end
        #1 rst = 1'b1;
        #1; checks++;
        if (!released(data)) begin errors++; $display("FAIL mid_rst_data_z: got %h expected released", data); end
        checks++;
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL mid_rst_wr_count: got %h expected 0000", wr_count); end
        bus_idle();
        release_and_wait();
        cyc(1'b1, 1'b0, 11'd20, 1'b1, 16'h0F0F);
        bus_idle();
        cyc(1'b1, 1'b0, 11'd20, 1'b1, 16'h5555);
        #2 rst = 1'b1;
        @(negedge clk);
        nOE = 1'b1; read = 1'b1; drv_en = 1'b0;
        release_and_wait();
        cyc(1'b0, 1'b1, 11'd20, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== ((CLR_CYC == 0) ? 16'h0F0F : 16'h0000)) begin
            errors++;
            $display("FAIL mid_write_dropped: got %h expected %h", data, (CLR_CYC == 0) ? 16'h0F0F : 16'h0000);
        end
        bus_idle();
        #1; checks++;
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL mid_wr_count: got %h expected 0000", wr_count); end
        checks++;
        if (rd_count !== 16'd1) begin errors++; $display("FAIL mid_rd_count: got %0d expected 1", rd_count); end
    endtask

`ifdef SRAM_RESPONDER_CLEAR_EN
    task automatic test_reset_mid_clear();
        @(negedge clk);
        rst = 1'b1;
        nOE = 1'b1; read = 1'b1; drv_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(posedge clk);
        #1; checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midclr_ready: got %b expected 0", ready); end
        @(negedge clk);
        rst = 1'b1;
        nOE = 1'b1; read = 1'b0; adrx = 11'd50; drv_en = 1'b1; drv = 16'h7777;
        @(negedge clk);
        release_and_wait();
        nOE = 1'b1; read = 1'b1; drv_en = 1'b0;
        checks++;
        if (wr_count !== 16'h0000) begin errors++; $display("FAIL midclr_wr_count: got %h expected 0000", wr_count); end
        cyc(1'b0, 1'b1, 11'd50, 1'b0, 16'h0000);
        #1; checks++;
        if (data !== 16'h0000) begin errors++; $display("FAIL midclr_mem50: got %h expected 0000", data); end
        bus_idle();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        nOE    = 1'b1;
        read   = 1'b1;
        adrx   = '0;
        drv    = '0;
        drv_en = 1'b0;
        test_reset();
        test_driver_pattern();
        test_held_read();
        test_illegal();
        test_saturation();
        test_reset_mid_op();
`ifdef SRAM_RESPONDER_CLEAR_EN
        test_reset_mid_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
